// File: rtl/st_stream_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : st_stream_feeder                                                 |
// | Purpose : Holds query s and target t {t,v,f} columns; streams them to the  |
// |           PE array controller and captures the last-PE write-back.         |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module st_stream_feeder #(
   parameter int S_MAX = 256,
   parameter int T_MAX = 1024,
   parameter int VEF_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load_valid,
   input  logic             i_load_sel,
   input  logic [1:0]       i_load_sym,
   output logic             o_load_ready,
   input  logic             i_start,
   input  logic             i_done,
   output logic             o_busy,
   output logic             o_data_valid,
   input  logic             i_update_s,
   output logic [1:0]       o_s,
   output logic             o_s_last,
   input  logic             i_update_t,
   output logic [1:0]       o_t,
   output logic [VEF_W-1:0] o_v,
   output logic [VEF_W-1:0] o_f,
   output logic             o_t_last,
   input  logic             i_wb_valid,
   input  logic [1:0]       i_wb_t,
   input  logic [VEF_W-1:0] i_wb_v,
   input  logic [VEF_W-1:0] i_wb_f,
   output logic             o_err
);

   localparam int S_AW = $clog2(S_MAX);
   localparam int T_AW = $clog2(T_MAX);
   localparam int E_W  = 2 + 2 * VEF_W;

   localparam logic [S_AW:0] c_s_max = (S_AW + 1)'(S_MAX);
   localparam logic [T_AW:0] c_t_max = (T_AW + 1)'(T_MAX);
   localparam logic [S_AW:0] c_s_one = (S_AW + 1)'(1);
   localparam logic [T_AW:0] c_t_one = (T_AW + 1)'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SERVE = 2'd2
   } state_t;

   state_t           r_state;
   logic [S_AW:0]    r_s_len;
   logic [T_AW:0]    r_t_len;
   logic [S_AW:0]    r_s_rd;
   logic [T_AW:0]    r_t_rd;
   logic [T_AW:0]    r_t_wr;
   logic [T_AW:0]    r_credit;
   logic             r_busy;
   logic             r_load_ready;
   logic             r_data_valid;
   logic             r_s_last;
   logic             r_t_last;
   logic             r_err;
   logic [1:0]       r_s_out;
   logic [1:0]       r_t_out;
   logic [VEF_W-1:0] r_v_out;
   logic [VEF_W-1:0] r_f_out;

   logic [1:0]       r_s_mem [0:S_MAX-1];
   logic [E_W-1:0]   r_t_mem [0:T_MAX-1];

   logic             w_serve;
   logic             w_start_ok;
   logic             w_s_full;
   logic             w_t_full;
   logic             w_s_wr;
   logic             w_t_ld;
   logic [S_AW-1:0]  w_s_wr_idx;
   logic [T_AW-1:0]  w_t_wr_idx;
   logic             w_pop_s;
   logic             w_pop_t;
   logic             w_pop_err;
   logic             w_wb_ok;
   logic             w_wb_drop;
   logic             w_fwd;
   logic [S_AW:0]    w_s_rd_nxt;
   logic [T_AW:0]    w_t_rd_nxt;
   logic [T_AW:0]    w_t_wr_nxt;
   logic [T_AW:0]    w_credit_nxt;

   assign w_serve    = (r_state == ST_SERVE);
   assign w_start_ok = (r_state == ST_LOAD) && i_start && (r_s_len != '0) && (r_t_len != '0);
   assign w_s_full   = (r_s_len >= c_s_max);
   assign w_t_full   = (r_t_len >= c_t_max);

   // The first symbol accepted in IDLE always lands at index 0 since lengths restart.
   assign w_s_wr     = i_load_valid && !i_load_sel &&
                       ((r_state == ST_IDLE) || ((r_state == ST_LOAD) && !w_start_ok && !w_s_full));
   assign w_t_ld     = i_load_valid && i_load_sel &&
                       ((r_state == ST_IDLE) || ((r_state == ST_LOAD) && !w_start_ok && !w_t_full));
   assign w_s_wr_idx = (r_state == ST_IDLE) ? '0 : r_s_len[S_AW-1:0];
   assign w_t_wr_idx = (r_state == ST_IDLE) ? '0 : r_t_len[T_AW-1:0];

   assign w_pop_s    = i_update_s && r_data_valid;
   assign w_pop_t    = i_update_t && r_data_valid;
   assign w_pop_err  = i_update_t && !r_data_valid;

   // A simultaneous pop frees a credit, so the write-back may land even at full credit.
   assign w_wb_ok    = i_wb_valid && w_serve && (w_pop_t || (r_credit < r_t_len));
   assign w_wb_drop  = i_wb_valid && w_serve && !w_pop_t && (r_credit >= r_t_len);

   assign w_s_rd_nxt = w_pop_s ? (r_s_rd + c_s_one) : r_s_rd;
   assign w_t_rd_nxt = !w_pop_t ? r_t_rd :
                       ((r_t_rd == r_t_len - c_t_one) ? '0 : r_t_rd + c_t_one);
   assign w_t_wr_nxt = !w_wb_ok ? r_t_wr :
                       ((r_t_wr == r_t_len - c_t_one) ? '0 : r_t_wr + c_t_one);

   always_comb begin
      w_credit_nxt = r_credit;
      case ({w_wb_ok, w_pop_t})
         2'b10:   w_credit_nxt = r_credit + c_t_one;
         2'b01:   w_credit_nxt = r_credit - c_t_one;
         default: w_credit_nxt = r_credit;
      endcase
   end

   assign w_fwd = w_wb_ok && (r_t_wr == w_t_rd_nxt);

   always_ff @(posedge clk) begin
      if (w_s_wr) begin
         r_s_mem[w_s_wr_idx] <= i_load_sym;
      end
      if (w_t_ld) begin
         r_t_mem[w_t_wr_idx] <= {i_load_sym, {(2 * VEF_W){1'b0}}};
      end else if (w_wb_ok) begin
         r_t_mem[r_t_wr[T_AW-1:0]] <= {i_wb_t, i_wb_v, i_wb_f};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_s_len      <= '0;
         r_t_len      <= '0;
         r_s_rd       <= '0;
         r_t_rd       <= '0;
         r_t_wr       <= '0;
         r_credit     <= '0;
         r_busy       <= 1'b0;
         r_load_ready <= 1'b1;
         r_data_valid <= 1'b0;
         r_s_last     <= 1'b0;
         r_t_last     <= 1'b0;
         r_err        <= 1'b0;
         r_s_out      <= '0;
         r_t_out      <= '0;
         r_v_out      <= '0;
         r_f_out      <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_load_valid) begin
                  r_state <= ST_LOAD;
                  r_err   <= 1'b0;
                  r_s_len <= i_load_sel ? '0 : c_s_one;
                  r_t_len <= i_load_sel ? c_t_one : '0;
               end
            end
            ST_LOAD: begin
               if (i_load_valid && !w_start_ok) begin
                  if (i_load_sel ? w_t_full : w_s_full) begin
                     r_err <= 1'b1;
                  end else if (i_load_sel) begin
                     r_t_len <= r_t_len + c_t_one;
                  end else begin
                     r_s_len <= r_s_len + c_s_one;
                  end
               end
               if (w_start_ok) begin
                  r_state      <= ST_SERVE;
                  r_s_rd       <= '0;
                  r_t_rd       <= '0;
                  r_t_wr       <= '0;
                  r_credit     <= r_t_len;
                  r_busy       <= 1'b1;
                  r_load_ready <= 1'b0;
                  r_data_valid <= 1'b0;
                  r_s_last     <= 1'b0;
                  r_t_last     <= 1'b0;
               end else if (i_start) begin
                  r_err <= 1'b1;
               end
            end
            ST_SERVE: begin
               r_s_rd   <= w_s_rd_nxt;
               r_t_rd   <= w_t_rd_nxt;
               r_t_wr   <= w_t_wr_nxt;
               r_credit <= w_credit_nxt;
               // Outputs reload every cycle so any write-back to the shown entry is visible.
               r_s_out  <= r_s_mem[w_s_rd_nxt[S_AW-1:0]];
               {r_t_out, r_v_out, r_f_out} <= w_fwd ? {i_wb_t, i_wb_v, i_wb_f}
                                                    : r_t_mem[w_t_rd_nxt[T_AW-1:0]];
               if (i_done) begin
                  r_state      <= ST_IDLE;
                  r_busy       <= 1'b0;
                  r_load_ready <= 1'b1;
                  r_data_valid <= 1'b0;
                  r_s_last     <= 1'b0;
                  r_t_last     <= 1'b0;
               end else begin
                  r_data_valid <= (w_s_rd_nxt < r_s_len) && (w_credit_nxt != '0);
                  r_s_last     <= (w_s_rd_nxt == r_s_len - c_s_one);
                  r_t_last     <= (w_t_rd_nxt == r_t_len - c_t_one);
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
         if (w_pop_err || w_wb_drop) begin
            r_err <= 1'b1;
         end
      end
   end

   assign o_load_ready = r_load_ready;
   assign o_busy       = r_busy;
   assign o_data_valid = r_data_valid;
   assign o_s          = r_s_out;
   assign o_s_last     = r_s_last;
   assign o_t          = r_t_out;
   assign o_v          = r_v_out;
   assign o_f          = r_f_out;
   assign o_t_last     = r_t_last;
   assign o_err        = r_err;

endmodule
`default_nettype wire

// File: doc/st_stream_feeder.md
Name: st_stream_feeder

Overview:
Data-processor side of the PE array interface. Stores the query sequence s and the target sequence t together with each t column's running v/f values. Streams s symbols and {t,v,f} entries to the PE array controller on its update requests, and captures the {t,v,f} written back from the last PE so the next pass over t uses them. Sits between the top-level sequence loader and the PE array controller.

Parameters:
S_MAX, 256, max query length (symbols); S_AW = clog2(S_MAX)
T_MAX, 1024, max target length (entries); T_AW = clog2(T_MAX)
VEF_W, 16, width of v/f values (matches V_E_F_Bit)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-low
i_load_valid  in  1  loader symbol valid
i_load_sel  in  1  0 = s symbol, 1 = t symbol
i_load_sym  in  2  nucleotide code
o_load_ready  out  1  loader may present a symbol
i_start  in  1  begin serving
i_done  in  1  controller finished (result valid); return to IDLE
o_busy  out  1  high in SERVE
o_data_valid  out  1  o_s and o_t/o_v/o_f both valid
i_update_s  in  1  pop current s symbol
o_s  out  2  current s symbol
o_s_last  out  1  o_s is the final s symbol
i_update_t  in  1  pop current t entry
o_t  out  2  current t symbol
o_v  out  VEF_W  current column v
o_f  out  VEF_W  current column f
o_t_last  out  1  current entry is index t_len-1
i_wb_valid  in  1  write-back entry valid
i_wb_t  in  2  write-back t
i_wb_v  in  VEF_W  write-back v
i_wb_f  in  VEF_W  write-back f
o_err  out  1  sticky protocol error

Behaviour:
- Reset: state IDLE. s_len, t_len, all pointers and credit = 0. All outputs 0, o_load_ready = 1.
- States: IDLE, LOAD, SERVE.
  - IDLE -> LOAD on the first i_load_valid; that symbol is stored.
  - LOAD -> SERVE on i_start when s_len > 0 and t_len > 0; otherwise i_start is ignored and o_err is set.
  - SERVE -> IDLE on i_done.
  - IDLE ignores i_start.
- Load:
  - o_load_ready = 1 in IDLE/LOAD, 0 in SERVE.
  - s symbol written to s_mem[s_len], s_len++.
  - t symbol written to t_mem[t_len] with v = 0, f = 0; t_len++.
  - Symbols beyond S_MAX/T_MAX are dropped and set o_err.
  - Lengths clear only on reset or on IDLE -> LOAD.
- Serve entry cycle: s_rd = 0, t_rd = 0, t_wr = 0, credit = t_len. Outputs are prefetched so o_s = s_mem[0] and o_t/v/f = entry 0 one cycle after entering SERVE.
- o_data_valid:
  - 1 when in SERVE, prefetch complete, s_rd < s_len and credit > 0.
  - Otherwise 0.
- s pop:
  - i_update_s with o_data_valid advances s_rd; o_s updates the next cycle.
  - o_s_last = (s_rd == s_len-1).
  - After popping the last symbol, s_rd = s_len and o_data_valid stays 0 until i_done.
- t pop:
  - i_update_t with o_data_valid advances t_rd (wraps t_len-1 -> 0) and decrements credit; new entry appears the next cycle.
  - o_t_last = (t_rd == t_len-1).
  - Pop with o_data_valid = 0 is ignored and sets o_err.
- Write-back:
  - i_wb_valid in SERVE writes {i_wb_t, i_wb_v, i_wb_f} to t_mem[t_wr], advances t_wr (wraps at t_len) and increments credit.
  - Outside SERVE it is ignored.
  - If credit would exceed t_len, the write is dropped and o_err is set.
- Simultaneous pop and write-back: credit is unchanged (net 0).
- Read-after-write: if write-back targets the entry being prefetched in the same cycle, the written data is forwarded to the outputs.
- o_busy is registered: 1 the cycle after entering SERVE, 0 the cycle after i_done.
- o_err clears only on reset or IDLE -> LOAD.
- Reset mid-operation: immediate return to reset values; memory contents are don't-care.

Test Plan:
- Load s = 2 symbols, t = 3 symbols, i_start -> SERVE; o_s = s[0], o_t = t[0], o_v = o_f = 0, o_data_valid = 1 within 2 cycles; o_busy = 1.
- Pop t three times with no write-back -> entries 0,1,2 in order; o_t_last = 1 on entry 2; credit = 0 then o_data_valid = 0.
- Write back v = 5, f = 3 for index 0 after the pass -> o_data_valid = 1, o_t = t[0], o_v = 5, o_f = 3; second pass uses the updated values.
- Same-cycle i_update_t and i_wb_valid at credit = 1 -> credit stays 1, o_data_valid stays 1, forwarded data correct when addresses collide.
- i_update_t while o_data_valid = 0, i_start with t_len = 0, 4th write-back with credit = 3 (t_len = 3) -> o_err = 1 each case, state and data unchanged.
- Assert rst_n low mid-SERVE -> next cycle all outputs 0, IDLE, o_load_ready = 1; reload and serve normally.
